// File: rtl/vae_rng_pkg.sv
// Shared definitions for the VAE sampler noise path: RNG byte width,
// CLT accumulator state type and the mean-removal offset.
package vae_rng_pkg;

  localparam int unsigned RNG_W = 8;

  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } gauss_state_t;

  // Mean of a sum of 2^n_log2 uniform bytes, rounded down: (255 * 2^n) / 2.
  function automatic int unsigned gauss_offset(input int unsigned n_log2);
    return (32'd255 << n_log2) >> 1;
  endfunction

endpackage

// File: rtl/gauss_clip.sv
// Combinational symmetric saturator: clamps a signed value to [-CLIP, +CLIP].
module gauss_clip #(
  parameter int unsigned OUT_W = 11,
  parameter int unsigned CLIP  = 443
) (
  input  logic signed [OUT_W-1:0] din_i,
  output logic signed [OUT_W-1:0] dout_o
);

  localparam logic signed [OUT_W-1:0] POS_LIM = OUT_W'(CLIP);
  localparam logic signed [OUT_W-1:0] NEG_LIM = -POS_LIM;

  // Clamp against the two limits; in-range values pass unchanged.
  always_comb begin
    dout_o = din_i;
    if (din_i > POS_LIM) begin
      dout_o = POS_LIM;
    end else if (din_i < NEG_LIM) begin
      dout_o = NEG_LIM;
    end
  end

endmodule

// File: rtl/gauss_clt.sv
// Central-limit Gaussian approximation: sums 2^N_LOG2 uniform RNG bytes,
// removes the mean and presents a signed epsilon on a valid/ready port.
// Optional output saturation to +/-CLIP is enabled by defining GAUSS_CLIP_EN.
// The RNG byte input is named rand_i because 'rand' is a reserved word.
module gauss_clt
  import vae_rng_pkg::*;
#(
  parameter int unsigned N_LOG2 = 2,
  parameter int unsigned OUT_W  = 8 + N_LOG2 + 1,
  parameter int unsigned CLIP   = 443
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [RNG_W-1:0]        rand_i,
  output logic signed [OUT_W-1:0] eps,
  output logic                    eps_vld,
  input  logic                    eps_rdy
);

  localparam int unsigned ACC_W = RNG_W + N_LOG2;
  localparam logic [N_LOG2-1:0] CNT_MAX = '1;
  localparam logic [OUT_W-1:0]  OFFSET  = OUT_W'(gauss_offset(N_LOG2));

  // Elaboration-time sanity checks on the configuration.
  if (N_LOG2 < 1 || N_LOG2 > 4) begin : g_bad_nlog2
    $error("gauss_clt: N_LOG2 must be in 1..4");
  end
  if (OUT_W != ACC_W + 1) begin : g_bad_outw
    $error("gauss_clt: OUT_W is derived and must equal 8+N_LOG2+1");
  end
  if (CLIP >= (32'd1 << (OUT_W - 1))) begin : g_bad_clip
    $error("gauss_clt: CLIP not representable in OUT_W signed bits");
  end

  gauss_state_t             state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [N_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0]  eps_q, eps_d;
  logic                     vld_q, vld_d;

  logic [ACC_W-1:0]         sum;
  logic [ACC_W-1:0]         load_src;
  logic signed [OUT_W-1:0]  eps_raw;
  logic signed [OUT_W-1:0]  eps_new;
  logic                     xfer;
  logic                     slot_free;

  // Datapath: running sum, centring subtraction on the zero-extended sum.
  always_comb begin
    sum       = acc_q + ACC_W'(rand_i);
    load_src  = (state_q == STALL) ? acc_q : sum;
    eps_raw   = $signed({1'b0, load_src} - OFFSET);
    xfer      = vld_q & eps_rdy;
    slot_free = ~vld_q | eps_rdy;
  end

`ifdef GAUSS_CLIP_EN
  gauss_clip #(
    .OUT_W (OUT_W),
    .CLIP  (CLIP)
  ) u_clip (
    .din_i  (eps_raw),
    .dout_o (eps_new)
  );
`else
  assign eps_new = eps_raw;
`endif

  // Next-state: accumulate, emit on last sample, park a finished sum in STALL.
  // A parked sum is flushed on eps_rdy even with en low: en only gates sampling.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    eps_d   = eps_q;
    vld_d   = vld_q;

    if (xfer) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      ACC: begin
        if (en) begin
          if (cnt_q != CNT_MAX) begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end else if (slot_free) begin
            eps_d = eps_new;
            vld_d = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d   = sum;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (eps_rdy) begin
          eps_d   = eps_new;
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      eps_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      eps_q   <= eps_d;
      vld_q   <= vld_d;
    end
  end

  assign eps     = eps_q;
  assign eps_vld = vld_q;

endmodule

// File: tb/tb_gauss_clt.sv
// Scoreboard bench for gauss_clt (N_LOG2=2). Expected epsilons are queued
// when a batch is issued; the monitor pops one per accepted transfer.
module tb_gauss_clt;

  localparam int N_LOG2 = 2;
  localparam int OUT_W  = 11;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic                    eps_rdy = 1'b0;
  logic [7:0]              rand_b = 8'h00;
  logic signed [OUT_W-1:0] eps;
  logic                    eps_vld;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  gauss_clt #(
    .N_LOG2 (N_LOG2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .rand_i  (rand_b),
    .eps     (eps),
    .eps_vld (eps_vld),
    .eps_rdy (eps_rdy)
  );

  function automatic int cl(input int v);
`ifdef GAUSS_CLIP_EN
    if (v > 443) return 443;
    if (v < -443) return -443;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic feed(input logic [7:0] b);
    en = 1'b1;
    rand_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever vld&&rdy.
  always @(negedge clk) begin
    if (!rst && eps_vld && eps_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_eps: got %0d expected none at %0t", int'(eps), $time);
      end else begin
        chk("eps_xfer", int'(eps), exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_eps", int'(eps), 0);
    chk("reset_vld", int'(eps_vld), 0);
    rst = 1'b0;

    // All 0xFF: latency of 4 edges, +510 every 4 cycles
    eps_rdy = 1'b1;
    exp_q.push_back(cl(510));
    exp_q.push_back(cl(510));
    for (int i = 0; i < 3; i++) feed(8'hFF);
    chk("latency_pre_vld", int'(eps_vld), 0);
    feed(8'hFF);
    chk("latency_vld", int'(eps_vld), 1);
    chk("latency_eps", int'(eps), cl(510));
    for (int i = 0; i < 4; i++) feed(8'hFF);
    idle(1);

    // All zero, mid-scale, alternating
    exp_q.push_back(cl(-510));
    for (int i = 0; i < 4; i++) feed(8'h00);
    exp_q.push_back(cl(2));
    for (int i = 0; i < 4; i++) feed(8'h80);
    exp_q.push_back(cl(0));
    for (int i = 0; i < 4; i++) feed((i % 2 == 0) ? 8'h00 : 8'hFF);
    idle(1);
    chk("after_xfer_vld", int'(eps_vld), 0);

    // Back-pressure: hold, STALL, then release with no bubble
    eps_rdy = 1'b0;
    exp_q.push_back(cl(-446));
    exp_q.push_back(cl(-382));
    exp_q.push_back(cl(510));
    for (int i = 0; i < 4; i++) feed(8'h10);
    chk("hold_first_eps", int'(eps), cl(-446));
    for (int i = 0; i < 4; i++) feed(8'h20);
    for (int i = 0; i < 4; i++) begin
      feed(8'hFF);
      chk("stall_hold_vld", int'(eps_vld), 1);
      chk("stall_hold_eps", int'(eps), cl(-446));
    end
    eps_rdy = 1'b1;
    idle(1);
    chk("no_bubble_vld", int'(eps_vld), 1);
    chk("no_bubble_eps", int'(eps), cl(-382));
    for (int i = 0; i < 4; i++) feed(8'hFF);
    idle(1);

    // Enable pause mid-batch
    exp_q.push_back(cl(510));
    feed(8'hFF);
    feed(8'hFF);
    idle(3);
    chk("pause_no_output", int'(eps_vld), 0);
    feed(8'hFF);
    feed(8'hFF);
    idle(1);

    // Asynchronous reset mid-accumulation discards the partial sum
    for (int i = 0; i < 3; i++) feed(8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", int'(eps_vld), 0);
    chk("async_rst_eps", int'(eps), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(cl(-510));
    for (int i = 0; i < 3; i++) feed(8'h00);
    chk("post_rst_pre_vld", int'(eps_vld), 0);
    feed(8'h00);
    chk("post_rst_vld", int'(eps_vld), 1);
    idle(3);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gauss_clt.md
# gauss_clt

Approximate-Gaussian noise stage that sits directly downstream of the 8-bit xorshift RNG in the VAE sampler. It consumes one uniform byte per cycle and sums 2^N_LOG2 bytes (central-limit approximation). It removes the mean and presents a signed, zero-centred epsilon on a valid/ready output. The reparameterisation datapath (z = mu + sigma·eps) consumes that output.

## Interface
- N_LOG2, 2, log2 of samples summed per epsilon (legal 1..4)
- OUT_W, 8+N_LOG2+1, signed epsilon width (derived; do not override)
- CLIP, 443, symmetric clamp magnitude; used only with GAUSS_CLIP_EN (443 ≈ 3σ for N_LOG2=2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  accumulate enable; low pauses sampling, state retained
- rand  in  8  uniform byte from the RNG, fresh every cycle
- eps  out  OUT_W  signed two's-complement epsilon
- eps_vld  out  1  eps holds an unconsumed value
- eps_rdy  in  1  consumer accepts eps this cycle

## Operation
- Registers:
  - acc: unsigned, 8+N_LOG2 bits.
  - cnt: N_LOG2 bits.
  - out_reg and eps_vld.
  - FSM: ACC or STALL.
- Reset values:
  - acc=0, cnt=0, state=ACC.
  - eps=0, eps_vld=0.
- Transfer: eps_vld && eps_rdy on a rising edge.
- ACC, en=1 and cnt<2^N_LOG2−1: acc+=rand, cnt++.
- ACC, en=1 and cnt==2^N_LOG2−1 (last sample):
  - Final sum S = acc+rand.
  - If out slot is free or transferring this edge: eps ← S − OFFSET, eps_vld=1, acc=0, cnt=0, stay ACC.
  - Otherwise: latch S into acc, go to STALL. cnt stays at max.
- STALL: rand is ignored (samples dropped, no back-pressure to the RNG).
  - On an edge with eps_rdy=1: eps ← acc − OFFSET, eps_vld stays 1, acc=0, cnt=0, go to ACC.
- Transfer with no new result ready: eps_vld → 0; eps keeps its last value.
- en=0: acc/cnt/state frozen; the output handshake still operates.
- OFFSET = (255·2^N_LOG2)>>1, i.e. 510 for N_LOG2=2.
- Subtraction is done at OUT_W bits with zero-extended S, so no overflow. Range ±OFFSET.
- eps is stable while eps_vld=1 and eps_rdy=0.

## Timing
- Throughput: one epsilon per 2^N_LOG2 enabled cycles when eps_rdy is held high.
- Latency: eps_vld rises on the same edge that samples the last byte. With en=1 from the first edge after reset release and N_LOG2=2, eps_vld=1 after edge 4.
- Simultaneous completion and transfer in ACC: new value loads, eps_vld stays 1, no bubble.
- Reset asserted mid-accumulation or mid-STALL: all state and outputs clear immediately (asynchronous); the partial sum is discarded.
- eps_rdy is ignored while eps_vld=0.

## Configuration
- GAUSS_CLIP_EN defined:
  - Value loaded into eps is saturated to [−CLIP, +CLIP].
  - Adds one compare/mux level; no added latency.
- GAUSS_CLIP_EN undefined:
  - eps is the raw centred sum.
  - CLIP is unused.

## Structure
- Shared package vae_rng_pkg holds:
  - RNG_W=8.
  - State enum type gauss_state_t {ACC, STALL}.
  - Function gauss_offset(n_log2).
- Sub-module gauss_clip: purely combinational saturator (OUT_W, CLIP). Instantiated only under GAUSS_CLIP_EN; the top otherwise wires through.

## Test plan
- Drive rand=0xFF constant, en=1, eps_rdy=1, N_LOG2=2 (macro off) -> eps=+510, eps_vld=1 after edge 4, repeating every 4 cycles.
- rand=0x00 constant -> eps=−510. rand=0x80 -> eps=+2. rand alternating 0x00/0xFF -> eps=0.
- eps_rdy=0 for 12 cycles with rand=0x10 then 0x20 batches:
  - First eps=64−510=−446 held stable.
  - STALL entered after the second batch (sum 128).
  - Releasing eps_rdy -> next eps=−382 with no bubble, accumulation restarts.
- en toggled low for 3 cycles after 2 samples of 0xFF, then 2 more 0xFF -> eps=+510; the pause does not corrupt the sum.
- Assert rst after 3 samples, release, feed 4×0x00 -> eps=−510; eps_vld/eps go 0 asynchronously during reset.
- GAUSS_CLIP_EN defined, CLIP=443:
  - rand=0xFF -> eps=+443; rand=0x00 -> eps=−443.
  - rand=0x80 -> eps=+2 (unclipped).
- Connected to the real XOR_RNG for 10,000 outputs -> mean within ±5, std 148±8.
